// File: rtl/cpu_pkg.sv
// Datapath-wide constants shared by the ALU decoder and the pipelined adders.
package cpu_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // ALU add/sub opcode bit, also the direct 'sub' control of pipe_add_sub
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit adder slice with carry in/out; one per pipeline stage.
module add_chunk #(
    parameter int W = 16
) (
    input  logic         cin,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined WIDTH-bit add/sub: one CHUNK-bit carry-chained slice per stage,
// global-stall valid/ready handshake, carry/overflow/zero flags from the last stage.
module pipe_add_sub
    import cpu_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("pipe_add_sub: STAGES must be in 1..WIDTH");
    end
    if (WIDTH % STAGES != 0) begin : g_bad_chunk
        $error("pipe_add_sub: WIDTH must be a multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;

    // The whole pipe moves or holds as one; a full output blocks everything.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = (sub == OP_SUB) ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO  = k * CHUNK;
        localparam int REM = WIDTH - LO - CHUNK;

        // oa/ob: operand bits not yet consumed, chunk k in the low CHUNK bits
        logic [WIDTH-LO-1:0] oa, ob;
        logic                ci, vi, co;
        logic [CHUNK-1:0]    cs;
        logic [LO+CHUNK-1:0] s_nxt, s_r;
        logic                c_r, v_r;

        if (k == 0) begin : g_first
            assign oa    = a;
            assign ob    = b_eff;
            assign ci    = sub;
            assign vi    = in_valid;
            assign s_nxt = cs;
        end else begin : g_next
            assign oa    = g_st[k-1].g_skew.ra;
            assign ob    = g_st[k-1].g_skew.rb;
            assign ci    = g_st[k-1].c_r;
            assign vi    = g_st[k-1].v_r;
            assign s_nxt = {cs, g_st[k-1].s_r};
        end

        add_chunk #(.W(CHUNK)) u_add (
            .cin  (ci),
            .x    (oa[CHUNK-1:0]),
            .y    (ob[CHUNK-1:0]),
            .s    (cs),
            .cout (co)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_r <= '0;
                c_r <= 1'b0;
                v_r <= 1'b0;
            end else if (adv) begin
                s_r <= s_nxt;
                c_r <= co;
                v_r <= vi;
            end
        end

        if (REM > 0) begin : g_skew
            logic [REM-1:0] ra, rb;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra <= '0;
                    rb <= '0;
                end else if (adv) begin
                    ra <= oa[WIDTH-LO-1:CHUNK];
                    rb <= ob[WIDTH-LO-1:CHUNK];
                end
            end
        end else begin : g_flags
            // Last stage: its chunk holds the operand MSBs, so signed overflow is local.
            logic ovf_r, zero_r;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end else if (adv) begin
                    ovf_r  <= (oa[CHUNK-1] == ob[CHUNK-1]) && (cs[CHUNK-1] != oa[CHUNK-1]);
                    zero_r <= ~|s_nxt;
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].v_r;
    assign sum       = g_st[STAGES-1].s_r;
    assign carry     = g_st[STAGES-1].c_r;
    assign overflow  = g_st[STAGES-1].g_flags.ovf_r;
    assign zero      = g_st[STAGES-1].g_flags.zero_r;
endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: four instances (STAGES 2, 1, 4, 32) on shared inputs,
// checked against a plain-arithmetic reference model.
module tb_pipe_add_sub;
    import cpu_pkg::*;

    localparam int W  = DATA_W;
    localparam int NI = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic sub = OP_ADD;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [NI-1:0] ir, ov, cy, of, zr;
    logic [NI-1:0][W-1:0] sm;

    int st[NI] = '{2, 1, 4, 32};
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_add_sub #(.WIDTH(W), .STAGES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .sub(sub),
        .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0]), .carry(cy[0]), .overflow(of[0]), .zero(zr[0]));
    pipe_add_sub #(.WIDTH(W), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .sub(sub),
        .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]), .carry(cy[1]), .overflow(of[1]), .zero(zr[1]));
    pipe_add_sub #(.WIDTH(W), .STAGES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .sub(sub),
        .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]), .carry(cy[2]), .overflow(of[2]), .zero(zr[2]));
    pipe_add_sub #(.WIDTH(W), .STAGES(32)) u_s32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b), .sub(sub),
        .out_valid(ov[3]), .out_ready(out_ready), .sum(sm[3]), .carry(cy[3]), .overflow(of[3]), .zero(zr[3]));

    // Reference: wide signed/unsigned arithmetic, no chunking.
    function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic op);
        res_t m;
        longint sx, sy, r;
        logic [W:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == OP_SUB) begin
            r   = sx - sy;
            m.s = x - y;
            m.c = (x >= y);
        end else begin
            r   = sx + sy;
            u   = {1'b0, x} + {1'b0, y};
            m.s = u[W-1:0];
            m.c = u[W];
        end
        m.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        m.z = (m.s == '0);
        return m;
    endfunction

    function automatic res_t got(int i);
        return '{s: sm[i], c: cy[i], v: of[i], z: zr[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic vld, logic [W-1:0] x, logic [W-1:0] y, logic op);
        in_valid = vld;
        a = x;
        b = y;
        sub = op;
    endtask

    task automatic drain();
        drive(1'b0, '0, '0, OP_ADD);
        out_ready = 1'b1;
        repeat (40) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, OP_ADD);
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (ov[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_valid[%0d]: got %b want 0", i, ov[i]);
            end
            n_cmp++;
            if (got(i) !== res_t'(0)) begin
                n_bad++;
                $display("FAIL reset_data[%0d]: got %h want 0", i, got(i));
            end
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ir !== {NI{1'b1}}) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want %b", ir, {NI{1'b1}});
        end
    endtask

    // Directed vectors on the STAGES=2 instance, expectations written out by hand.
    task automatic test_directed();
        logic [W-1:0] va[4] = '{32'h0000FFFF, 32'h7FFFFFFF, 32'd5, 32'd3};
        logic [W-1:0] vb[4] = '{32'd1, 32'd1, 32'd5, 32'd5};
        logic         vs[4] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB};
        res_t         ex[4];
        ex[0] = '{s: 32'h00010000, c: 1'b0, v: 1'b0, z: 1'b0};
        ex[1] = '{s: 32'h80000000, c: 1'b0, v: 1'b1, z: 1'b0};
        ex[2] = '{s: 32'h00000000, c: 1'b1, v: 1'b0, z: 1'b1};
        ex[3] = '{s: 32'hFFFFFFFE, c: 1'b0, v: 1'b0, z: 1'b0};
        drain();
        for (int t = 0; t < 4; t++) begin
            drive(1'b1, va[t], vb[t], vs[t]);
            tick();
            drive(1'b0, '0, '0, OP_ADD);
            n_cmp++;
            if (ov[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL dir_early[%0d]: out_valid got %b want 0", t, ov[0]);
            end
            tick();
            n_cmp++;
            if (ov[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL dir_valid[%0d]: got %b want 1", t, ov[0]);
            end
            n_cmp++;
            if (got(0) !== ex[t]) begin
                n_bad++;
                $display("FAIL dir_data[%0d]: got %h want %h", t, got(0), ex[t]);
            end
            tick();
            n_cmp++;
            if (ov[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL dir_single[%0d]: out_valid got %b want 0", t, ov[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa[8], ob[8];
        logic         os[8];
        res_t         ex[8];
        logic         ev;
        drain();
        for (int j = 0; j < 8; j++) begin
            oa[j] = $urandom;
            ob[j] = ($urandom_range(0, 3) == 0) ? oa[j] : $urandom;
            os[j] = logic'($urandom_range(0, 1));
            ex[j] = model(oa[j], ob[j], os[j]);
        end
        for (int n = 0; n < 41; n++) begin
            if (n < 8) drive(1'b1, oa[n], ob[n], os[n]);
            else       drive(1'b0, '0, '0, OP_ADD);
            tick();
            for (int i = 0; i < NI; i++) begin
                ev = (n + 1 >= st[i]) && (n + 1 < st[i] + 8);
                n_cmp++;
                if (ov[i] !== ev) begin
                    n_bad++;
                    $display("FAIL b2b_valid[%0d] edge %0d: got %b want %b", i, n + 1, ov[i], ev);
                end
                if (ev) begin
                    n_cmp++;
                    if (got(i) !== ex[n + 1 - st[i]]) begin
                        n_bad++;
                        $display("FAIL b2b_data[%0d] op %0d: got %h want %h", i, n + 1 - st[i], got(i), ex[n + 1 - st[i]]);
                    end
                end
            end
        end
    endtask

    // Backpressure on the STAGES=2 instance, scoreboard by queue.
    task automatic test_stall();
        res_t q[$];
        res_t hold_v, e;
        logic held = 1'b0;
        int   acc_n = 0;
        int   out_n = 0;
        drain();
        for (int cyc = 0; cyc < 50; cyc++) begin
            out_ready = !((cyc >= 4 && cyc < 8) || (cyc >= 15 && cyc < 18));
            if (cyc < 24) drive(1'b1, $urandom, $urandom, logic'($urandom_range(0, 1)));
            else          drive(1'b0, '0, '0, OP_ADD);
            #1;
            if (held) begin
                n_cmp++;
                if (ov[0] !== 1'b1 || got(0) !== hold_v) begin
                    n_bad++;
                    $display("FAIL stall_hold cyc %0d: got %b/%h want 1/%h", cyc, ov[0], got(0), hold_v);
                end
            end
            held = ov[0] && !out_ready;
            hold_v = got(0);
            if (held) begin
                n_cmp++;
                if (ir[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_in_ready cyc %0d: got %b want 0", cyc, ir[0]);
                end
            end
            if (ov[0] && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stall_extra cyc %0d: got result %h want none", cyc, got(0));
                end else begin
                    e = q.pop_front();
                    out_n++;
                    if (got(0) !== e) begin
                        n_bad++;
                        $display("FAIL stall_data cyc %0d: got %h want %h", cyc, got(0), e);
                    end
                end
            end
            if (in_valid && ir[0]) begin
                q.push_back(model(a, b, sub));
                acc_n++;
            end
            tick();
        end
        n_cmp++;
        if (q.size() != 0 || out_n != acc_n || acc_n < 10) begin
            n_bad++;
            $display("FAIL stall_count: got %0d out of %0d accepted (left %0d), want all", out_n, acc_n, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic [W-1:0] x, y;
        res_t         e;
        drain();
        drive(1'b1, $urandom, $urandom, OP_ADD);
        tick();
        drive(1'b1, $urandom, $urandom, OP_SUB);
        tick();
        drive(1'b0, '0, '0, OP_ADD);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ov !== '0 || sm !== '0) begin
            n_bad++;
            $display("FAIL rst_flight: got valid %b sum0 %h want all 0", ov, sm[0]);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            n_cmp++;
            if (ov !== '0) begin
                n_bad++;
                $display("FAIL rst_stale cycle %0d: got %b want 0", n, ov);
            end
        end
        x = $urandom;
        y = $urandom;
        e = model(x, y, OP_SUB);
        drive(1'b1, x, y, OP_SUB);
        for (int k = 1; k <= 33; k++) begin
            tick();
            drive(1'b0, '0, '0, OP_ADD);
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (ov[i] !== (k == st[i])) begin
                    n_bad++;
                    $display("FAIL rst_latency[%0d] edge %0d: got %b want %b", i, k, ov[i], (k == st[i]));
                end
                if (k == st[i]) begin
                    n_cmp++;
                    if (got(i) !== e) begin
                        n_bad++;
                        $display("FAIL rst_data[%0d]: got %h want %h", i, got(i), e);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_add_sub.md
Name: pipe_add_sub

Overview:
- Parametrised, pipelined add/subtract unit; successor to the single-cycle 32-bit combinational adder.
- Splits a WIDTH-bit operation into STAGES carry-chained chunks, one chunk per pipeline stage.
- Uses a valid/ready handshake with backpressure. Produces carry, signed overflow and zero flags.
- Serves the multi-cycle/pipelined datapath: ALU add path, branch-target and PC adders, where the clock period cannot cover a full-width ripple carry.

Parameters:
- WIDTH, 32: operand/result width in bits; must be a multiple of STAGES.
- STAGES, 2: pipeline depth, which is also the number of chunks. Legal range 1..WIDTH.
- CHUNK, WIDTH/STAGES: derived chunk width. Localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  unit can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry  out  1  carry out of the MSB. For sub: 1 = no borrow (A >= B unsigned).
- overflow  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0: all stage valid bits, out_valid, sum, carry, overflow and zero are 0; in_ready is 1 after reset release.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational).
- A transfer occurs on a cycle with in_valid && in_ready. When adv = 0, every stage holds its data and valid bit unchanged.
- Subtract form: b_eff = sub ? ~b : b, cin0 = sub.
- Stage k (0..STAGES-1) adds chunk k of a and b_eff plus the carry from stage k-1; stage 0 uses cin0. It registers the chunk result and the carry-out.
- Operand chunks not yet consumed travel with the operation in skew registers, so no input needs to be held beyond the accept cycle.
- Latency: exactly STAGES cycles from the accept edge to out_valid = 1, assuming no stalls.
- Throughput: 1 operation per cycle while out_ready = 1.
- Results leave in acceptance order; no reordering, no drops.
- Flags are computed in the last stage:
  - carry = cout of the final chunk.
  - overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]); the MSB of a and b_eff is carried through the skew registers.
  - zero = ~|sum, over all registered chunks.
- Output stays stable while out_valid && !out_ready (AXI-style hold).
- Bubbles: when in_valid = 0 on an advancing cycle, a stage-0 bubble enters with valid = 0.
- Simultaneous output accept and input accept in the same cycle is legal; the pipeline shifts by one.
- STAGES = 1: a single registered full-width adder with latency 1.
- STAGES = WIDTH: 1-bit chunks; must synthesise and simulate correctly.
- Reset asserted mid-operation: all in-flight operations are discarded. No stale result may appear after release.
- Wrap-around: sum is modulo 2^WIDTH; carry and overflow report the wrap, no saturation.
- Elaboration fails (generate-time $error) if WIDTH % STAGES != 0.

Decomposition:
- Shared package (cpu_pkg): ADDR_W/DATA_W constants and the op encoding constant OP_ADD = 0, OP_SUB = 1 used by the ALU decoder.
- One natural sub-module: add_chunk, a combinational CHUNK-bit adder with ports cin, x, y, s, cout. It is instantiated STAGES times by a generate loop.
- All pipeline/skew registers and handshake logic stay in pipe_add_sub.

Test Plan:
- WIDTH = 32, STAGES = 2, out_ready = 1: a = 0x0000FFFF, b = 0x00000001, sub = 0 -> after 2 cycles sum = 0x00010000, carry = 0, overflow = 0, zero = 0. This checks carry propagation across the chunk boundary.
- a = 0x7FFFFFFF, b = 1, sub = 0 -> sum = 0x80000000, overflow = 1, carry = 0.
- a = 5, b = 5, sub = 1 -> sum = 0, zero = 1, carry = 1. Then a = 3, b = 5, sub = 1 -> sum = 0xFFFFFFFE, carry = 0, overflow = 0.
- Back-to-back stream of 8 random ops with out_ready = 1 -> 8 results on consecutive cycles, in order, matching the reference model.
- Stall: hold out_ready = 0 for 4 cycles with in_valid = 1 -> in_ready drops once out_valid = 1, and sum/flags stay constant. On release, no result is lost or duplicated.
- Reset: assert rst_n = 0 with 2 ops in flight -> out_valid = 0 immediately. After release, the first out_valid occurs STAGES cycles after the next accept. Repeat with STAGES = 1 and STAGES = 4.
